// File: rtl/mem_lsu_if.sv
// mem_lsu_if: bundles the pipeline-side request/response handshake and the data memory port of
// the MEM-stage load/store unit.
//   master: the pipeline + memory environment (drives req_*, mem_ack, mem_rdata)
//   slave : the load/store unit (drives req_ready, stall, resp_*, mem_req/we/be/addr/wdata)
interface mem_lsu_if;
  // Pipeline request
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Pipeline response
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // Data memory port
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Accepts one load/store per handshake, issues a word-aligned
// memory request with byte enables, waits for mem_ack (with a MAX_WAIT-cycle timeout) and returns
// sign/zero-extended load data with a one-cycle resp_valid pulse.
// Optional feature: define LSU_MISALIGN_TRAP_EN to complete misaligned half/word requests with
// resp_err instead of issuing them with the low address bits ignored.
// Ports:
//   i_clk   - clock, rising edge
//   i_reset - asynchronous active-low reset
//   io_bus  - mem_lsu_if.slave: req_*/resp_*/stall to the pipeline, mem_* to data memory
module mem_lsu #(
  parameter int unsigned MAX_WAIT = 16  // legal range 2..255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  mem_lsu_if.slave   io_bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [7:0] LastCnt = 8'(MAX_WAIT - 1);

  state_e      r_state, w_state_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic        r_err, w_err_d;
  logic        r_we, r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;

  logic        w_idle, w_busy, w_resp, w_accept, w_trap;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_idle   = (r_state == StIdle);
  assign w_busy   = (r_state == StBusy);
  assign w_resp   = (r_state == StResp);
  assign w_accept = w_idle & io_bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  // Half with addr[0] set, or word (size 10/11) with any low bit set.
  assign w_trap = ((io_bus.req_size == 2'b01) & io_bus.req_addr[0]) |
                  (io_bus.req_size[1] & (|io_bus.req_addr[1:0]));
`else
  assign w_trap = 1'b0;
`endif

  // Lane pattern and replicated store data from the latched request.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  // Load extraction; only reaches outputs through r_rdata.
  assign w_byte = io_bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = io_bus.mem_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = io_bus.mem_rdata;
    case (r_size)
      2'b00:   w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = io_bus.mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_rdata_d = r_rdata;
    w_err_d   = r_err;
    case (r_state)
      StIdle: begin
        w_cnt_d = 8'd0;
        if (w_accept) begin
          w_rdata_d = 32'd0;
          w_err_d   = w_trap;
          w_state_d = w_trap ? StResp : StBusy;
        end
      end
      StBusy: begin
        // Ack takes priority over a timeout reached in the same cycle.
        if (io_bus.mem_ack) begin
          w_rdata_d = r_we ? 32'd0 : w_load;
          w_err_d   = 1'b0;
          w_state_d = StResp;
        end else if (r_cnt == LastCnt) begin
          w_rdata_d = 32'd0;
          w_err_d   = 1'b1;
          w_state_d = StResp;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_rdata <= w_rdata_d;
      r_err   <= w_err_d;
      if (w_accept) begin
        r_we    <= io_bus.req_we;
        r_uns   <= io_bus.req_unsigned;
        r_size  <= io_bus.req_size;
        r_addr  <= io_bus.req_addr;
        r_wdata <= io_bus.req_wdata;
      end
    end
  end

  // Outputs decode from state/registers only; stall is the single path from req_valid.
  assign io_bus.req_ready  = w_idle;
  assign io_bus.stall      = (w_idle & io_bus.req_valid) | w_busy;
  assign io_bus.resp_valid = w_resp;
  assign io_bus.resp_rdata = w_resp ? r_rdata : 32'd0;
  assign io_bus.resp_err   = w_resp & r_err;
  assign io_bus.mem_req    = w_busy;
  assign io_bus.mem_we     = w_busy & r_we;
  assign io_bus.mem_be     = w_busy ? w_be : 4'b0000;
  assign io_bus.mem_addr   = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
  assign io_bus.mem_wdata  = w_busy ? w_wdata : 32'd0;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu (MAX_WAIT = 16).
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_lsu_if bus ();

  mem_lsu #(.MAX_WAIT(16)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full access: accept, `waits` cycles without ack, ack with `rd`, response, back to idle.
  task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd, input int waits, input logic [31:0] e_addr,
                           input logic [3:0] e_be, input logic [31:0] e_wdata,
                           input logic [31:0] e_rdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    #1;
    chk({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, " stall_idle"}, {31'd0, bus.stall}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk({tag, " mem_req"}, {31'd0, bus.mem_req}, 32'd1);
    chk({tag, " mem_we"}, {31'd0, bus.mem_we}, {31'd0, we});
    chk({tag, " mem_addr"}, bus.mem_addr, e_addr);
    chk({tag, " mem_be"}, {28'd0, bus.mem_be}, {28'd0, e_be});
    if (we) chk({tag, " mem_wdata"}, bus.mem_wdata, e_wdata);
    chk({tag, " resp_early"}, {31'd0, bus.resp_valid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      // Request inputs must be ignored while busy.
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'hFFFF_FFF0;
      step();
      chk({tag, " wait_req"}, {31'd0, bus.mem_req}, 32'd1);
      chk({tag, " wait_addr"}, bus.mem_addr, e_addr);
      bus.req_valid = 1'b0;
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hA5A5_A5A5;
    chk({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, " resp_err"}, {31'd0, bus.resp_err}, 32'd0);
    chk({tag, " resp_rdata"}, bus.resp_rdata, e_rdata);
    chk({tag, " resp_stall"}, {31'd0, bus.stall}, 32'd0);
    chk({tag, " resp_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
    step();
    chk({tag, " idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, " idle_resp"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    int req_cycles;
    int lat;

    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = 32'd0;

    // Reset state
    step();
    chk("rst ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst stall", {31'd0, bus.stall}, 32'd0);
    chk("rst mem_be", {28'd0, bus.mem_be}, 32'd0);
    rst_n = 1'b1;
    step();

    // Stray ack in idle is ignored
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("idle_ack resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("idle_ack ready", {31'd0, bus.req_ready}, 32'd1);

    // Byte loads across all lanes, signed and unsigned
    do_access("lb3", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'h80FF7F01, 0, 32'h10, 4'b1000, 32'd0,
              32'hFFFFFF80);
    do_access("lbu3", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'h80FF7F01, 0, 32'h10, 4'b1000, 32'd0,
              32'h00000080);
    do_access("lb0", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'h80FF7F01, 0, 32'h10, 4'b0001, 32'd0,
              32'h00000001);
    do_access("lb1", 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 32'h80FF7F01, 0, 32'h10, 4'b0010, 32'd0,
              32'h0000007F);
    do_access("lb2", 1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 32'h80FF7F01, 0, 32'h10, 4'b0100, 32'd0,
              32'hFFFFFFFF);
    do_access("lbu2", 1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 32'h80FF7F01, 0, 32'h10, 4'b0100, 32'd0,
              32'h000000FF);

    // Half loads
    do_access("lh_hi", 1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 32'h9ABC1234, 0, 32'h20, 4'b1100, 32'd0,
              32'hFFFF9ABC);
    do_access("lhu_hi", 1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 32'h9ABC1234, 0, 32'h20, 4'b1100,
              32'd0, 32'h00009ABC);
    do_access("lh_lo", 1'b0, 2'b01, 1'b0, 32'h20, 32'd0, 32'h9ABC8234, 0, 32'h20, 4'b0011, 32'd0,
              32'hFFFF8234);

    // Stores
    do_access("sb", 1'b1, 2'b00, 1'b0, 32'h41, 32'h12345678, 32'hFFFFFFFF, 0, 32'h40, 4'b0010,
              32'h78787878, 32'd0);
    do_access("sh", 1'b1, 2'b01, 1'b0, 32'h42, 32'h12345678, 32'hFFFFFFFF, 0, 32'h40, 4'b1100,
              32'h56785678, 32'd0);
    do_access("sw", 1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFEF00D, 32'd0, 1, 32'h44, 4'b1111,
              32'hCAFEF00D, 32'd0);

    // Size 11 behaves as word; lw with 3 wait cycles (resp 5 cycles after accept)
    do_access("lw11", 1'b0, 2'b11, 1'b1, 32'h50, 32'd0, 32'h8000_0001, 0, 32'h50, 4'b1111, 32'd0,
              32'h8000_0001);
    do_access("lw_w3", 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 3, 32'h100, 4'b1111,
              32'd0, 32'hDEADBEEF);

    // Ack on the 16th busy cycle wins over the timeout
    do_access("lw_w15", 1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 32'h0BADF00D, 15, 32'h104, 4'b1111,
              32'd0, 32'h0BADF00D);

    // Timeout: mem_req high exactly 16 cycles, then error response
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h200;
    step();
    bus.req_valid = 1'b0;
    req_cycles = 0;
    lat        = 1;
    for (int i = 0; i < 40 && !bus.resp_valid; i++) begin
      if (bus.mem_req) req_cycles++;
      step();
      lat++;
    end
    chk("tmo resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("tmo req_cycles", req_cycles, 32'd16);
    chk("tmo latency", lat, 32'd17);
    chk("tmo resp_err", {31'd0, bus.resp_err}, 32'd1);
    chk("tmo resp_rdata", bus.resp_rdata, 32'd0);
    step();
    chk("tmo idle", {31'd0, bus.req_ready}, 32'd1);

    // Misaligned word at 0x06
`ifdef LSU_MISALIGN_TRAP_EN
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h06;
    step();
    bus.req_valid = 1'b0;
    chk("mis mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mis resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("mis resp_err", {31'd0, bus.resp_err}, 32'd1);
    chk("mis resp_rdata", bus.resp_rdata, 32'd0);
    step();
    chk("mis idle", {31'd0, bus.req_ready}, 32'd1);
`else
    do_access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 32'h11223344, 0, 32'h04, 4'b1111,
              32'd0, 32'h11223344);
    do_access("lh_mis", 1'b0, 2'b01, 1'b1, 32'h23, 32'd0, 32'hBEEF0000, 0, 32'h20, 4'b1100,
              32'd0, 32'h0000BEEF);
`endif

    // Reset during BUSY aborts with no response
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h300;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("rmid busy", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rmid ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rmid resp", {31'd0, bus.resp_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rmid no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    do_access("lw_post", 1'b0, 2'b10, 1'b0, 32'h304, 32'd0, 32'h13579BDF, 2, 32'h304, 4'b1111,
              32'd0, 32'h13579BDF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
